// File: rtl/uart_bus_monitor.sv
// uart_bus_monitor: a host on the UART sends byte commands that this block turns into single accesses on the 16-bit system bus.
// Optional: define UART_BUS_MONITOR_BLOCK_EN to add the 'L' block-write command.
module uart_bus_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  // Handshakes:
  // - rx is a one-cycle strobe with no backpressure. A byte that arrives while no command
  //   byte is expected is discarded.
  // - tx_data holds steady while tx_valid is high. The byte moves on a clock edge where
  //   tx_valid and tx_ready are both high.

  localparam logic [7:0] OPC_WRITE = 8'h57;
  localparam logic [7:0] OPC_READ  = 8'h52;
  localparam logic [7:0] RPL_OK    = 8'h4B;
  localparam logic [7:0] RPL_UNK   = 8'h3F;
`ifdef UART_BUS_MONITOR_BLOCK_EN
  localparam logic [7:0] OPC_BLOCK = 8'h4C;
`endif
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_COUNT, S_DATA, S_REQ, S_ACC, S_RDWAIT, S_RESP
  } state_t;

  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_BLOCK} op_t;

  state_t           state;
  op_t              op;
  logic [15:0]      addr;
  logic [CNT_W-1:0] timer;
`ifdef UART_BUS_MONITOR_BLOCK_EN
  logic [8:0]       remain;
`endif

  logic collecting;
  logic timed_out;

  assign collecting = (state == S_ADDR_H) || (state == S_ADDR_L) ||
                      (state == S_COUNT)  || (state == S_DATA);
  assign timed_out  = (timer == TO_LIMIT);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op        <= OP_WRITE;
      addr      <= 16'h0000;
      timer     <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      bus_req   <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
`ifdef UART_BUS_MONITOR_BLOCK_EN
      remain    <= 9'd0;
`endif
    end else begin
      // The inter-byte timer restarts on every received byte. It never counts past its
      // limit: the command is abandoned first.
      if (rx_valid)
        timer <= '0;
      else if (collecting && !timed_out && (timer != '1))
        timer <= timer + 1'b1;

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              OPC_WRITE: begin op <= OP_WRITE; state <= S_ADDR_H; end
              OPC_READ:  begin op <= OP_READ;  state <= S_ADDR_H; end
`ifdef UART_BUS_MONITOR_BLOCK_EN
              OPC_BLOCK: begin op <= OP_BLOCK; state <= S_ADDR_H; end
`endif
              default: begin
                tx_data  <= RPL_UNK;
                tx_valid <= 1'b1;
                state    <= S_RESP;
              end
            endcase
          end
        end

        S_ADDR_H: begin
          if (rx_valid) begin
            addr[15:8] <= rx_data;
            state      <= S_ADDR_L;
          end else if (timed_out) begin
            state <= S_IDLE;
          end
        end

        S_ADDR_L: begin
          if (rx_valid) begin
            addr[7:0] <= rx_data;
            if (op == OP_READ) begin
              bus_req <= 1'b1;
              state   <= S_REQ;
            end else if (op == OP_BLOCK) begin
              state <= S_COUNT;
            end else begin
              state <= S_DATA;
            end
          end else if (timed_out) begin
            state <= S_IDLE;
          end
        end

`ifdef UART_BUS_MONITOR_BLOCK_EN
        S_COUNT: begin
          if (rx_valid) begin
            remain <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            state  <= S_DATA;
          end else if (timed_out) begin
            state <= S_IDLE;
          end
        end
`endif

        S_DATA: begin
          if (rx_valid) begin
            mem_wdata <= rx_data;
            bus_req   <= 1'b1;
            state     <= S_REQ;
          end else if (timed_out) begin
            state <= S_IDLE;
          end
        end

        S_REQ: begin
          if (bus_gnt) begin
            mem_addr <= addr;
            mem_we   <= (op != OP_READ);
            state    <= S_ACC;
          end
        end

        S_ACC: begin
          mem_we <= 1'b0;
          if (op == OP_READ) begin
            state <= S_RDWAIT;
`ifdef UART_BUS_MONITOR_BLOCK_EN
          end else if ((op == OP_BLOCK) && (remain != 9'd1)) begin
            // A block write gives up the bus after each byte, then waits for the next byte.
            remain  <= remain - 9'd1;
            addr    <= addr + 16'd1;
            bus_req <= 1'b0;
            timer   <= '0;
            state   <= S_DATA;
`endif
          end else begin
            tx_data  <= RPL_OK;
            tx_valid <= 1'b1;
            bus_req  <= 1'b0;
            state    <= S_RESP;
          end
        end

        S_RDWAIT: begin
          tx_data  <= mem_rdata;
          tx_valid <= 1'b1;
          bus_req  <= 1'b0;
          state    <= S_RESP;
        end

        S_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_bus_monitor.md
Name: uart_bus_monitor

Overview:
- Serial-side initiator on the 16-bit system memory bus, used for host-driven debug and program loading.
- Consumes command bytes from a UART receiver byte stream and decodes read/write commands.
- Arbitrates for the bus with a req/gnt handshake, performs single accesses on the synchronous system memory, and returns reply bytes to a UART transmitter byte stream.

Parameters:
- TIMEOUT_CYCLES, 50000000: max clk cycles between bytes of one command before the partial command is abandoned.
- CNT_W, 26: width of the inter-byte timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_valid  input  1  one-cycle strobe; rx_data holds a received byte
- rx_data  input  8  received byte
- tx_valid  output  1  reply byte pending
- tx_data  output  8  reply byte
- tx_ready  input  1  transmitter accepts tx_data when tx_valid & tx_ready
- bus_req  output  1  request bus ownership
- bus_gnt  input  1  bus granted; CPU is stalled while high
- mem_addr  output  16  bus address
- mem_wdata  output  8  bus write data
- mem_we  output  1  write strobe, one cycle
- mem_rdata  input  8  read data, valid the cycle after the address is presented
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; tx_valid, bus_req, mem_we and busy = 0; mem_addr = 0x0000; mem_wdata = 0x00; tx_data = 0x00; timeout counter = 0.
- Commands (ASCII opcode):
  - 'W'(0x57) AH AL D: writes D to {AH,AL}, then replies 'K'(0x4B).
  - 'R'(0x52) AH AL: replies with the byte at {AH,AL}.
  - Any other opcode in IDLE: replies '?'(0x3F) and returns to IDLE.
- State sequence:
  - IDLE -> ADDR_H -> ADDR_L -> (W only) DATA -> REQ -> ACC -> (R only) RDWAIT -> RESP -> IDLE.
  - Each of ADDR_H, ADDR_L and DATA advances on rx_valid and latches rx_data.
- REQ:
  - bus_req = 1; hold until bus_gnt = 1.
  - bus_req stays high through ACC, RDWAIT and RESP entry, and drops in the cycle RESP is entered.
- ACC (one cycle, bus_gnt high):
  - mem_addr = latched address.
  - W: mem_we = 1 for exactly this cycle.
  - R: mem_we = 0.
- RDWAIT: capture mem_rdata into tx_data at the end of this cycle.
- mem_addr holds its last value outside ACC/RDWAIT. mem_we is 0 in every state except ACC on a write.
- If bus_gnt drops during ACC or RDWAIT: the access still completes; the result is undefined but the FSM still replies.
- RESP:
  - tx_valid = 1 with tx_data stable until tx_ready = 1.
  - Return to IDLE the cycle after the handshake.
  - rx_valid arriving in RESP or REQ/ACC/RDWAIT is dropped, with no reply.
- Timeout:
  - The counter clears on every rx_valid and on entry to ADDR_H.
  - It increments each cycle in ADDR_H, ADDR_L or DATA.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, no bus access, no reply.
  - It saturates and never wraps.
- Address boundary: 0xFFFF is a valid address; no auto-increment in base mode.
- Reset mid-operation:
  - Immediate return to reset values, including dropping bus_req and tx_valid.
  - Any partially sent reply is lost.

Optional Feature:
- Macro: UART_BUS_MONITOR_BLOCK_EN.
- Defined:
  - Adds opcode 'L'(0x4C) AH AL N followed by N data bytes (N = 0 means 256).
  - Each data byte is written at address {AH,AL}+i, with 16-bit wrap (0xFFFF -> 0x0000).
  - One req/gnt/ACC sequence per byte.
  - The timeout applies between every byte.
  - A single 'K' is sent after the last write. A timeout mid-block abandons the remainder with no reply; bytes already written stay written.
- Undefined: 'L' is an unknown opcode and gets the '?' reply.

Test Plan:
- Write then read:
  - Send 57 12 34 A5 with bus_gnt tied 1 -> exactly one cycle of mem_we = 1 with mem_addr = 0x1234 and mem_wdata = 0xA5; then tx_data = 0x4B.
  - Send 52 12 34 with a RAM model -> tx_data = 0xA5.
- Grant delay: hold bus_gnt = 0 for 100 cycles after the last byte of 57 00 10 3C -> bus_req high throughout and mem_we stays 0 until the cycle after bus_gnt rises; then reply 0x4B.
- Unknown opcode and backpressure: send 0x41 with tx_ready = 0 for 20 cycles -> tx_valid held with tx_data = 0x3F stable; handshake, then busy = 0.
- Timeout: with TIMEOUT_CYCLES = 16, send 57 80 then idle for 20 cycles -> return to IDLE, no bus_req, no tx_valid. A following 52 80 00 is decoded normally.
- Reset mid-command: assert reset during REQ -> next cycle bus_req = 0, tx_valid = 0, busy = 0, mem_addr = 0x0000.
- BLOCK_EN wrap: send 4C FF FF 03 11 22 33 -> writes 0xFFFF=11, 0x0000=22, 0x0001=33; single 0x4B reply.
